lenet_hls_mac_pipe: RTL and testbench

LENET_HLS_MAC_PIPE -- requirements
Module: lenet_hls_mac_pipe

---
 rtl/lenet_hls_mac_pkg.sv | 32 +++
 rtl/lenet_hls_mac_pipe_mul.sv | 56 +++++
 rtl/lenet_hls_mac_pipe.sv | 134 +++++++++++++
 tb/tb_lenet_hls_mac_pipe.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_hls_mac_pkg.sv
// Shared helpers for the LeNet MAC pipeline: product width, saturation
// limits and the legal parameter ranges.
package lenet_hls_mac_pkg;

  localparam int ACC_WIDTH_MAX = 48;
  localparam int NUM_STAGE_MIN = 2;
  localparam int NUM_STAGE_MAX = 5;

  // Full-precision width of a signed a_w x b_w product
  function automatic int prod_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  // Largest positive value of an acc_w-bit signed number (zero-extended to 64)
  function automatic logic [63:0] sat_max(input int acc_w);
    return (64'd1 << (acc_w - 1)) - 64'd1;
  endfunction

  // Most negative value of an acc_w-bit signed number (low acc_w bits are valid)
  function automatic logic [63:0] sat_min(input int acc_w);
    return ~sat_max(acc_w);
  endfunction

  // True when the widths and stage count are inside the supported range
  function automatic bit params_ok(input int a_w, input int b_w,
                                   input int acc_w, input int stages);
    return (a_w >= 1) && (b_w >= 1) &&
           (acc_w >= prod_width(a_w, b_w)) && (acc_w <= ACC_WIDTH_MAX) &&
           (stages >= NUM_STAGE_MIN) && (stages <= NUM_STAGE_MAX);
  endfunction

endpackage

// File: rtl/lenet_hls_mac_pipe_mul.sv
// Registered signed multiplier with a side-band tag that travels alongside
// the product. STAGES registers deep; every stage advances only on ce.
module lenet_hls_mac_pipe_mul
  import lenet_hls_mac_pkg::*;
#(
  parameter int A_W    = 12,
  parameter int B_W    = 6,
  parameter int STAGES = 2,
  parameter int TAG_W  = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  ce,
  input  logic signed [A_W-1:0]                 a,
  input  logic signed [B_W-1:0]                 b,
  input  logic        [TAG_W-1:0]               tag_in,
  output logic signed [prod_width(A_W,B_W)-1:0] p,
  output logic        [TAG_W-1:0]               tag_out
);

  localparam int P_W = prod_width(A_W, B_W);

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic signed [P_W-1:0] p_q;
      logic        [TAG_W-1:0] tag_q;
      if (gi == 0) begin : g_first
        // First stage: form the full-precision product from sign-extended operands
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            p_q   <= '0;
            tag_q <= '0;
          end else if (ce) begin
            p_q   <= P_W'(a) * P_W'(b);
            tag_q <= tag_in;
          end
        end
      end else begin : g_rest
        // Later stages: plain delay registers, free for retiming into the multiplier
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            p_q   <= '0;
            tag_q <= '0;
          end else if (ce) begin
            p_q   <= g_stage[gi-1].p_q;
            tag_q <= g_stage[gi-1].tag_q;
          end
        end
      end
    end
  endgenerate

  assign p       = g_stage[STAGES-1].p_q;
  assign tag_out = g_stage[STAGES-1].tag_q;

endmodule

// File: rtl/lenet_hls_mac_pipe.sv
// Windowed multiply-accumulate for the LeNet HLS datapath. Beats are
// multiplied in NUM_STAGE-1 registered stages, summed in one accumulator
// stage, and the window sum is emitted on the beat carrying in_last.
// A stalled result freezes the whole pipeline.
// Build option: define LENET_HLS_MAC_SAT_EN to saturate the accumulator on
// overflow; otherwise it wraps. out_ovf reports overflow in both builds.
module lenet_hls_mac_pipe
  import lenet_hls_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = 12,
  parameter int DIN1_WIDTH = 6,
  parameter int ACC_WIDTH  = 24,
  parameter int NUM_STAGE  = 3
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  input  logic                         in_first,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACC_WIDTH-1:0]  dout,
  output logic                         out_ovf
);

  localparam int P_W = prod_width(DIN0_WIDTH, DIN1_WIDTH);

  generate
    if (!params_ok(DIN0_WIDTH, DIN1_WIDTH, ACC_WIDTH, NUM_STAGE)) begin : g_param_check
      $error("lenet_hls_mac_pipe: DIN/ACC widths or NUM_STAGE out of range");
    end
  endgenerate

`ifdef LENET_HLS_MAC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH));
`endif

  logic                        pipe_en;
  logic [2:0]                  tag_in;
  logic [2:0]                  tag_out;
  logic signed [P_W-1:0]       prod;
  logic                        m_valid;
  logic                        m_first;
  logic                        m_last;

  logic signed [ACC_WIDTH-1:0] acc_reg;
  logic                        ovf_reg;
  logic                        start_pending_reg;
  logic signed [ACC_WIDTH-1:0] dout_reg;
  logic                        out_ovf_reg;
  logic                        out_valid_reg;

  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc_base;
  logic        [ACC_WIDTH:0]   sum_wide;
  logic                        win_start;
  logic                        step_ovf;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic                        ovf_next;

  // Global stall: everything advances only when the output slot can move
  assign pipe_en  = !out_valid_reg || out_ready;
  assign in_ready = pipe_en;

  // Flags are masked with in_valid so unaccepted beats leave no trace
  assign tag_in  = {in_valid, in_valid & in_first, in_valid & in_last};
  assign m_valid = tag_out[2];
  assign m_first = tag_out[1];
  assign m_last  = tag_out[0];

  lenet_hls_mac_pipe_mul #(
    .A_W    (DIN0_WIDTH),
    .B_W    (DIN1_WIDTH),
    .STAGES (NUM_STAGE - 1),
    .TAG_W  (3)
  ) u_mul (
    .clk     (ap_clk),
    .rst_n   (ap_rst_n),
    .ce      (pipe_en),
    .a       (din0),
    .b       (din1),
    .tag_in  (tag_in),
    .p       (prod),
    .tag_out (tag_out)
  );

  // Accumulate step: restart or add, detect signed overflow, wrap or clamp
  always_comb begin
    prod_ext  = ACC_WIDTH'(prod);
    win_start = m_first || start_pending_reg;
    acc_base  = win_start ? '0 : acc_reg;
    sum_wide  = {acc_base[ACC_WIDTH-1], acc_base} + {prod_ext[ACC_WIDTH-1], prod_ext};
    step_ovf  = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
    acc_next  = sum_wide[ACC_WIDTH-1:0];
`ifdef LENET_HLS_MAC_SAT_EN
    if (step_ovf) begin
      acc_next = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
`endif
    ovf_next  = (!win_start && ovf_reg) || step_ovf;
  end

  // Accumulator and output register; a new window is armed after every last beat
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_reg           <= '0;
      ovf_reg           <= 1'b0;
      start_pending_reg <= 1'b1;
      dout_reg          <= '0;
      out_ovf_reg       <= 1'b0;
      out_valid_reg     <= 1'b0;
    end else if (pipe_en) begin
      if (m_valid) begin
        acc_reg           <= acc_next;
        ovf_reg           <= ovf_next;
        start_pending_reg <= m_last;
      end
      out_valid_reg <= m_valid && m_last;
      if (m_valid && m_last) begin
        dout_reg    <= acc_next;
        out_ovf_reg <= ovf_next;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign dout      = dout_reg;
  assign out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_lenet_hls_mac_pipe.sv
// Self-checking bench for lenet_hls_mac_pipe: an arithmetic model predicts each
// window result when its last beat is accepted; a monitor collects results as
// the DUT hands them off; each scenario task compares the two queues.
`timescale 1ns/1ps
module tb_lenet_hls_mac_pipe;

  localparam int DIN0_WIDTH = 12;
  localparam int DIN1_WIDTH = 6;
  localparam int ACC_WIDTH  = 19;
  localparam int NUM_STAGE  = 3;
  localparam longint ACC_MAX  = (longint'(1) << (ACC_WIDTH - 1)) - 1;
  localparam longint ACC_MIN  = -ACC_MAX - 1;
  localparam longint ACC_SPAN = longint'(1) << ACC_WIDTH;

  logic                         ap_clk;
  logic                         ap_rst_n;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DIN0_WIDTH-1:0] din0;
  logic signed [DIN1_WIDTH-1:0] din1;
  logic                         in_first;
  logic                         in_last;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [ACC_WIDTH-1:0]  dout;
  logic                         out_ovf;

  lenet_hls_mac_pipe #(
    .DIN0_WIDTH (DIN0_WIDTH),
    .DIN1_WIDTH (DIN1_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .NUM_STAGE  (NUM_STAGE)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .in_first  (in_first),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .out_ovf   (out_ovf)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  typedef struct {
    longint dout;
    bit     ovf;
    int     t;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  longint m_acc   = 0;
  bit     m_ovf   = 1'b0;
  bit     m_start = 1'b1;

  function automatic void model_beat(input int a, input int b, input bit f,
                                     input bit l, input int t);
    longint p;
    longint s;
    res_t   r;
    p = longint'(a) * longint'(b);
    if (f || m_start) begin
      m_acc = p;
      m_ovf = 1'b0;
    end else begin
      s = m_acc + p;
      if (s > ACC_MAX || s < ACC_MIN) begin
        m_ovf = 1'b1;
`ifdef LENET_HLS_MAC_SAT_EN
        s = (s > ACC_MAX) ? ACC_MAX : ACC_MIN;
`else
        s = (s > ACC_MAX) ? s - ACC_SPAN : s + ACC_SPAN;
`endif
      end
      m_acc = s;
    end
    m_start = l;
    if (l) begin
      r.dout = m_acc;
      r.ovf  = m_ovf;
      r.t    = t;
      exp_q.push_back(r);
    end
  endfunction

  function automatic void model_reset();
    m_acc   = 0;
    m_ovf   = 1'b0;
    m_start = 1'b1;
    exp_q.delete();
  endfunction

  // Output monitor: records each handed-off result and the cycle it first appeared
  bit seen   = 1'b0;
  int appear = 0;
  initial begin
    res_t o;
    forever begin
      @(negedge ap_clk);
      #3;
      if (!ap_rst_n) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (!seen) begin
          seen   = 1'b1;
          appear = cyc;
        end
        if (out_ready) begin
          o.dout = dout;
          o.ovf  = out_ovf;
          o.t    = appear;
          obs_q.push_back(o);
          seen = 1'b0;
        end
      end
    end
  end

  // Present one beat and hold it until accepted (bounded)
  task automatic send(input int a, input int b, input bit f, input bit l);
    int n;
    n = 0;
    @(negedge ap_clk);
    in_valid = 1'b1;
    din0     = a[DIN0_WIDTH-1:0];
    din1     = b[DIN1_WIDTH-1:0];
    in_first = f;
    in_last  = l;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge ap_clk);
      #1;
      n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL send_accept: beat (%0d,%0d) in_ready=%b after %0d cycles, required 1", a, b, in_ready, n);
    end else begin
      $display("beat  din0=%0d din1=%0d first=%b last=%b cyc=%0d", a, b, f, l, cyc);
      model_beat(a, b, f, l, cyc);
    end
  endtask

  task automatic idle();
    @(negedge ap_clk);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  // Pop n results and compare value, overflow flag and (optionally) latency
  task automatic check_results(input string name, input int n, input bit chk_lat);
    res_t e;
    res_t o;
    for (int k = 0; k < n; k++) begin
      int w;
      w = 0;
      while (obs_q.size() == 0 && w < 100) begin
        @(negedge ap_clk);
        #4;
        w++;
      end
      checks++;
      if (obs_q.size() == 0 || exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s_result: observed=%0d expected=%0d queued results, required both nonzero",
                 name, obs_q.size(), exp_q.size());
      end else begin
        e = exp_q.pop_front();
        o = obs_q.pop_front();
        $display("result %s dout=%0d ovf=%b appear=%0d", name, o.dout, o.ovf, o.t);
        checks++;
        if (o.dout !== e.dout) begin
          failures++;
          $display("FAIL %s_dout: got %0d required %0d", name, o.dout, e.dout);
        end
        checks++;
        if (o.ovf !== e.ovf) begin
          failures++;
          $display("FAIL %s_ovf: got %b required %b", name, o.ovf, e.ovf);
        end
        if (chk_lat) begin
          checks++;
          if (o.t - e.t !== NUM_STAGE) begin
            failures++;
            $display("FAIL %s_latency: got %0d cycles required %0d", name, o.t - e.t, NUM_STAGE);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    ap_rst_n  = 1'b0;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    din0      = '0;
    din1      = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge ap_clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++;
    if (dout !== '0) begin failures++; $display("FAIL reset_dout: got %0d required 0", dout); end
    checks++;
    if (out_ovf !== 1'b0) begin failures++; $display("FAIL reset_out_ovf: got %b required 0", out_ovf); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    model_reset();
    $display("reset released cyc=%0d", cyc);
  endtask

  task automatic test_single();
    send(-2048, -32, 1'b1, 1'b1);
    idle();
    check_results("single", 1, 1'b1);
    @(negedge ap_clk);
    #2;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_drop_valid: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_window();
    send(100, 3, 1'b1, 1'b0);
    send(-50, 7, 1'b0, 1'b0);
    send(2047, 31, 1'b0, 1'b1);
    idle();
    check_results("window", 1, 1'b1);
  endtask

  // Invalid cycles carrying junk data and flags must not disturb the window
  task automatic test_ignore();
    send(7, -3, 1'b0, 1'b0);
    @(negedge ap_clk);
    in_valid = 1'b0;
    in_first = 1'b1;
    in_last  = 1'b1;
    din0     = 12'sd1234;
    din1     = -6'sd17;
    repeat (3) @(negedge ap_clk);
    send(4, 4, 1'b0, 1'b1);
    idle();
    check_results("ignore", 1, 1'b1);
  endtask

  task automatic test_first_mid();
    send(3, 3, 1'b1, 1'b0);
    send(4, 4, 1'b0, 1'b0);
    send(10, 10, 1'b1, 1'b0);
    send(1, 1, 1'b0, 1'b1);
    idle();
    check_results("first_mid", 1, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic signed [ACC_WIDTH-1:0] held;
    bit found;
    found = 1'b0;
    fork
      begin
        send(3, 4, 1'b1, 1'b0);
        send(5, 6, 1'b0, 1'b1);
        send(-7, 8, 1'b1, 1'b0);
        send(100, -2, 1'b0, 1'b0);
        send(9, 9, 1'b0, 1'b0);
        send(-1, 1, 1'b0, 1'b1);
        idle();
      end
      begin
        for (int i = 0; i < 40 && !found; i++) begin
          @(negedge ap_clk);
          if (out_valid) found = 1'b1;
        end
        checks++;
        if (!found) begin
          failures++;
          $display("FAIL b2b_first_result: out_valid=%b required 1 within 40 cycles", out_valid);
        end else begin
          out_ready = 1'b0;
          held = dout;
          for (int i = 0; i < 5; i++) begin
            #2;
            checks++;
            if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_stall_in_ready: got %b required 0", in_ready); end
            checks++;
            if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_stall_out_valid: got %b required 1", out_valid); end
            checks++;
            if (dout !== held) begin failures++; $display("FAIL b2b_stall_dout: got %0d required %0d", dout, held); end
            @(negedge ap_clk);
          end
        end
        out_ready = 1'b1;
      end
    join
    check_results("b2b", 2, 1'b0);
  endtask

  task automatic test_overflow();
    send(2047, 31, 1'b1, 1'b0);
    repeat (3) send(2047, 31, 1'b0, 1'b0);
    send(2047, 31, 1'b0, 1'b1);
    idle();
    check_results("overflow", 1, 1'b1);
  endtask

  // Reset mid-window: outputs clear at once, nothing emitted, next window clean
  task automatic test_reset_mid();
    send(1, 1, 1'b1, 1'b0);
    send(2, 2, 1'b0, 1'b0);
    idle();
    #2;
    ap_rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_out_valid: got %b required 0", out_valid); end
    checks++;
    if (dout !== '0) begin failures++; $display("FAIL rstmid_dout: got %0d required 0", dout); end
    checks++;
    if (out_ovf !== 1'b0) begin failures++; $display("FAIL rstmid_out_ovf: got %b required 0", out_ovf); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_in_ready: got %b required 1", in_ready); end
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (8) @(negedge ap_clk);
    #4;
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL rstmid_no_result: %0d results emitted, required 0", obs_q.size());
      obs_q.delete();
    end
    send(5, 5, 1'b1, 1'b1);
    idle();
    check_results("rstmid_next", 1, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_window();
    test_ignore();
    test_first_mid();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    repeat (3) @(negedge ap_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
